// File: rtl/bp_defs.sv
// Shared definitions for the branch predictor: 2-bit direction counter
// encodings, the counter values used on allocation and reset, and helpers
// that derive the BTB index and tag widths from the top-level parameters.
package bp_defs;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;  // strong not-taken
  localparam ctr_t CTR_WNT = 2'b01;  // weak not-taken
  localparam ctr_t CTR_WT  = 2'b10;  // weak taken
  localparam ctr_t CTR_ST  = 2'b11;  // strong taken

  // Counter written when a taken branch / jump is allocated, and after reset.
  localparam ctr_t ALLOC_CTR_BRANCH = CTR_WT;
  localparam ctr_t ALLOC_CTR_JUMP   = CTR_ST;
  localparam ctr_t RESET_CTR        = CTR_WNT;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // PC bits [1:0] are ignored, so the tag is whatever sits above the index.
  function automatic int unsigned tag_w(input int unsigned width, input int unsigned entries);
    return width - $clog2(entries) - 2;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolve-side training signals of the branch predictor.
//   pc / pred_hit / pred_taken / pred_npc        : combinational lookup
//   upd_valid / upd_pc / upd_jump / upd_taken /
//   upd_target / upd_mispred                     : one-cycle training port
//   flush_all                                    : synchronous invalidate-all
//   stat_lookups / stat_updates / stat_mispred   : only with BP_STATS_EN
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_npc;
  logic             upd_valid;
  logic [WIDTH-1:0] upd_pc;
  logic             upd_jump;
  logic             upd_taken;
  logic [WIDTH-1:0] upd_target;
  logic             upd_mispred;
  logic             flush_all;
`ifdef BP_STATS_EN
  logic [31:0]      stat_lookups;
  logic [31:0]      stat_updates;
  logic [31:0]      stat_mispred;

  modport master (
    output pc, upd_valid, upd_pc, upd_jump, upd_taken, upd_target, upd_mispred, flush_all,
    input  pred_hit, pred_taken, pred_npc, stat_lookups, stat_updates, stat_mispred
  );
  modport slave (
    input  pc, upd_valid, upd_pc, upd_jump, upd_taken, upd_target, upd_mispred, flush_all,
    output pred_hit, pred_taken, pred_npc, stat_lookups, stat_updates, stat_mispred
  );
`else
  modport master (
    output pc, upd_valid, upd_pc, upd_jump, upd_taken, upd_target, upd_mispred, flush_all,
    input  pred_hit, pred_taken, pred_npc
  );
  modport slave (
    input  pc, upd_valid, upd_pc, upd_jump, upd_taken, upd_target, upd_mispred, flush_all,
    output pred_hit, pred_taken, pred_npc
  );
`endif
endinterface

// File: rtl/sat_ctr2.sv
// Next-state logic of a 2-bit saturating direction counter.
//   cur      : current counter value
//   taken    : step toward taken (1) or not-taken (0)
//   force_st : jump, counter goes straight to strong-taken
//   nxt      : next counter value
module sat_ctr2
  import bp_defs::*;
(
  input  ctr_t cur,
  input  logic taken,
  input  logic force_st,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (force_st) begin
      nxt = CTR_ST;
    end else if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'b01;
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters. Lookup is
// combinational from the entry registers; training writes at the clock edge.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : branch_predictor_if slave (lookup, training, flush, optional stats)
// Optional feature: define BP_STATS_EN for the stat_* counters.
module branch_predictor
  import bp_defs::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 16
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);
  localparam int unsigned TAG_W = tag_w(WIDTH, ENTRIES);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic             jump_q   [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  // Lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx   = bus.pc[IDX_W+1:2];
  assign lk_tag   = bus.pc[WIDTH-1:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);

  assign bus.pred_hit   = lk_hit;
  assign bus.pred_taken = lk_taken;
  assign bus.pred_npc   = lk_taken ? target_q[lk_idx] : bus.pc + WIDTH'(4);

  // Training
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  ctr_t             up_ctr_nxt;

  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[WIDTH-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_ctr2 u_sat_ctr2 (
    .cur      (ctr_q[up_idx]),
    .taken    (bus.upd_taken),
    .force_st (bus.upd_jump),
    .nxt      (up_ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
        ctr_q[i]    <= RESET_CTR;
      end
    end else if (bus.flush_all) begin
      // Flush wins over a same-cycle update, which is dropped.
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_nxt;
        if (bus.upd_taken) target_q[up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        // Not-taken misses are never allocated.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        jump_q[up_idx]   <= bus.upd_jump;
        ctr_q[up_idx]    <= bus.upd_jump ? ALLOC_CTR_JUMP : ALLOC_CTR_BRANCH;
      end
    end
  end

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.pc[1:0], bus.upd_pc[1:0]};

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, updates_q, mispred_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_q <= '0;
      updates_q <= '0;
      mispred_q <= '0;
    end else if (bus.flush_all) begin
      lookups_q <= '0;
      updates_q <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= sat_inc32(lookups_q);
      if (bus.upd_valid) updates_q <= sat_inc32(updates_q);
      if (bus.upd_valid && bus.upd_mispred) mispred_q <= sat_inc32(mispred_q);
    end
  end

  assign bus.stat_lookups = lookups_q;
  assign bus.stat_updates = updates_q;
  assign bus.stat_mispred = mispred_q;
`else
  // Mispredict reporting only feeds the statistics.
  logic unused_mispred;
  assign unused_mispred = bus.upd_mispred;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.WIDTH(WIDTH)) bus ();

  branch_predictor #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one record per BTB slot, counter kept as an integer.
  bit          m_valid  [ENTRIES];
  bit [31:0]   m_tag    [ENTRIES];
  bit [31:0]   m_target [ENTRIES];
  bit          m_jump   [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_lookups, m_updates, m_mispred;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot(input bit [31:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic bit [31:0] tag_of(input bit [31:0] a);
    return a >> (IDX_W + 2);
  endfunction

  function automatic bit [31:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_jump[i] = 0; m_ctr[i] = 1;
    end
    m_lookups = 0; m_updates = 0; m_mispred = 0;
  endtask

  // Applied right after a rising edge, using the inputs that edge sampled.
  task automatic model_edge();
    int s;
    bit hit;
    if (!rst) begin
      model_reset();
      return;
    end
    if (bus.flush_all) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      m_lookups = 0; m_updates = 0; m_mispred = 0;
      return;
    end
    m_lookups++;
    if (bus.upd_valid) begin
      m_updates++;
      if (bus.upd_mispred) m_mispred++;
      s   = slot(bus.upd_pc);
      hit = m_valid[s] && m_tag[s] == tag_of(bus.upd_pc);
      if (hit) begin
        if (bus.upd_jump) m_ctr[s] = 3;
        else if (bus.upd_taken) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
        else m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        if (bus.upd_taken) m_target[s] = bus.upd_target;
      end else if (bus.upd_taken) begin
        m_valid[s]  = 1;
        m_tag[s]    = tag_of(bus.upd_pc);
        m_target[s] = bus.upd_target;
        m_jump[s]   = bus.upd_jump;
        m_ctr[s]    = bus.upd_jump ? 3 : 2;
      end
    end
  endtask

  task automatic check_outputs();
    int s;
    bit hit, tkn;
    bit [31:0] npc;
    s   = slot(bus.pc);
    hit = m_valid[s] && m_tag[s] == tag_of(bus.pc);
    tkn = hit && (m_jump[s] || m_ctr[s] >= 2);
    npc = tkn ? m_target[s] : bus.pc + 32'd4;
    check("pred_hit", 32'(bus.pred_hit), 32'(hit));
    check("pred_taken", 32'(bus.pred_taken), 32'(tkn));
    check("pred_npc", bus.pred_npc, npc);
`ifdef BP_STATS_EN
    check("stat_lookups", bus.stat_lookups, sat32(m_lookups));
    check("stat_updates", bus.stat_updates, sat32(m_updates));
    check("stat_mispred", bus.stat_mispred, sat32(m_mispred));
`endif
  endtask

  task automatic drive(input bit [31:0] pc, input bit uv, input bit [31:0] upc, input bit uj,
                       input bit ut, input bit [31:0] utgt, input bit um, input bit fl);
    bus.pc = pc; bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_jump = uj;
    bus.upd_taken = ut; bus.upd_target = utgt; bus.upd_mispred = um; bus.flush_all = fl;
  endtask

  // Check the combinational view mid-cycle, then advance the model across the edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic look(input bit [31:0] pc);
    drive(pc, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic train(input bit [31:0] lpc, input bit [31:0] upc, input bit uj, input bit ut,
                       input bit [31:0] tgt, input bit um);
    drive(lpc, 1, upc, uj, ut, tgt, um, 0);
    cycle();
  endtask

  function automatic bit [31:0] rand_pc();
    bit [31:0] t;
    t = (($urandom % 8) == 0) ? 32'h03FF_FFFF : 32'($urandom % 3);
    return (t << (IDX_W + 2)) | ((32'($urandom) % ENTRIES) << 2) | (32'($urandom) % 4);
  endfunction

  initial begin
    model_reset();
    drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_outputs();
    cycle();
    cycle();
    rst = 1'b1;

    // Same-cycle lookup and first allocation: old contents seen this cycle.
    train(32'h40, 32'h40, 0, 1, 32'h100, 0);
    check("same_cycle_hit", 32'(bus.pred_hit), 32'd1);
    check("trained_npc", bus.pred_npc, 32'h100);
    look(32'h40);
    train(32'h40, 32'h40, 0, 0, 32'h0, 1);
    train(32'h40, 32'h40, 0, 0, 32'h0, 1);
    check("ctr_snt_npc", bus.pred_npc, 32'h44);
    check("ctr_snt_taken", 32'(bus.pred_taken), 32'd0);
    look(32'h40);
    for (int i = 0; i < 3; i++) train(32'h40, 32'h40, 0, 1, 32'h100, 0);
    look(32'h40);
    train(32'h40, 32'h40, 0, 0, 32'h0, 0);  // 11 -> 10, still taken
    look(32'h40);

    // Not-taken miss does not allocate.
    train(32'h80, 32'h80, 0, 0, 32'h0, 0);
    look(32'h80);

    // Aliasing on the same slot.
    train(32'h440, 32'h440, 0, 1, 32'h200, 0);
    look(32'h40);
    look(32'h440);
    check("alias_npc", bus.pred_npc, 32'h200);

    // Flush with a simultaneous update: update dropped.
    drive(32'h440, 1, 32'hC0, 0, 1, 32'h500, 0, 1);
    cycle();
    look(32'hC0);
    look(32'h440);

    // Jump allocation and a subsequent not-taken report.
    train(32'h60, 32'h60, 1, 1, 32'h300, 0);
    look(32'h60);
    train(32'h60, 32'h60, 0, 0, 32'h0, 1);
    look(32'h60);
    check("jump_still_taken", 32'(bus.pred_taken), 32'd1);
    look(32'hFFFF_FFFE);  // pc+4 wraps

    // Five updates, two of them flagged mispredicted, after a clearing flush.
    drive(32'h0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    for (int i = 0; i < 5; i++) train(32'h60, 32'h60, 1, 1, 32'h300, (i == 1 || i == 3));
`ifdef BP_STATS_EN
    @(negedge clk);
    check("stat_upd5", bus.stat_updates, 32'd5);
    check("stat_mis2", bus.stat_mispred, 32'd2);
    @(posedge clk);
    model_edge();
    #1;
`endif

    // Randomized traffic over a few tags per slot.
    for (int n = 0; n < 400; n++) begin
      drive(rand_pc(), ($urandom % 2) == 0, rand_pc(), ($urandom % 5) == 0,
            ($urandom % 3) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 4) == 0,
            ($urandom % 50) == 0);
      cycle();
    end

    // Asynchronous reset mid-run after training.
    train(32'h40, 32'h40, 0, 1, 32'h700, 0);
    drive(32'h40, 1, 32'h40, 0, 1, 32'h800, 0, 0);
    #1;
    check_outputs();
    check("pre_reset_hit", 32'(bus.pred_hit), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("async_rst_npc", bus.pred_npc, 32'h44);
    cycle();
    rst = 1'b1;
    // First edge with reset released accepts this update.
    train(32'h40, 32'h40, 0, 1, 32'h900, 0);
    look(32'h40);
    check("post_reset_npc", bus.pred_npc, 32'h900);
    for (int n = 0; n < 100; n++) begin
      drive(rand_pc(), ($urandom % 2) == 0, rand_pc(), ($urandom % 5) == 0,
            ($urandom % 3) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 4) == 0, 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the next-generation pipelined CPU.
- Sits beside the IF stage: direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters.
- Given the fetch PC, it returns a predicted next PC in the same cycle.
- Trained by the resolving stage (ID/EX) through a one-cycle update port; replaces the always-not-taken/serial-PC policy.

Parameters:
- WIDTH, 32, PC/target width in bits.
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- IDX_W, log2(ENTRIES), index width; derived, not overridden.
- TAG_W, WIDTH-IDX_W-2, tag width; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  WIDTH  fetch PC to look up.
- pred_hit  out  1  valid entry with matching tag found.
- pred_taken  out  1  prediction is taken.
- pred_npc  out  WIDTH  predicted next PC.
- upd_valid  in  1  a resolved control-flow instruction is reported this cycle.
- upd_pc  in  WIDTH  PC of the resolved instruction.
- upd_jump  in  1  1 = unconditional jump, 0 = conditional branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  WIDTH  actual taken target.
- upd_mispred  in  1  pipeline flushed due to this instruction.
- flush_all  in  1  synchronous invalidate of every entry.

Behaviour:
- Addressing:
  - index = pc[IDX_W+1:2]; tag = pc[WIDTH-1:IDX_W+2].
  - Same mapping applies to upd_pc.
  - pc[1:0] are ignored.
- Entry contents: valid, tag, target, jump flag, ctr[1:0].
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is purely combinational from the state registers (zero latency):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (jump | ctr[1]).
  - pred_npc = pred_taken ? target : pc+4. Addition wraps modulo 2^WIDTH.
- Update is registered and takes effect at the clock edge when upd_valid=1:
  - Hit on upd_pc:
    - Branch: ctr saturates toward taken (+1, max 11) or not-taken (-1, min 00).
    - Jump: ctr forced to 11.
    - When upd_taken=1, target is overwritten with upd_target.
  - Miss and upd_taken=1: allocate, replacing any occupant. Sets valid=1, tag, target=upd_target, jump=upd_jump, ctr = jump ? 11 : 10.
  - Miss and upd_taken=0: no change (no allocation of not-taken branches).
- Same-cycle lookup and update of one index: lookup returns the pre-update contents; the new contents are visible from the next cycle.
- flush_all=1: all valid bits cleared at the edge. flush_all has priority over a simultaneous upd_valid; that update is dropped.
- Reset (rst=0, asynchronous, any time including mid-update): all valid=0, ctr=01, targets/tags 0.
  - Outputs during and after reset: pred_hit=0, pred_taken=0, pred_npc=pc+4.
  - First update is accepted on the first rising edge with rst=1.
- upd_mispred affects only the optional statistics; it never changes prediction state.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds three outputs, each 32 bits, each saturating at 0xFFFFFFFF, each reset to 0 by rst and cleared by flush_all:
  - stat_lookups: counts cycles with rst=1.
  - stat_updates: counts upd_valid.
  - stat_mispred: counts upd_valid & upd_mispred.
- When undefined, the ports and registers do not exist; predictor behaviour is identical in both builds.

Decomposition:
- Shared package/header bp_defs: counter encodings (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST), allocation values, index/tag width functions.
- One sub-module sat_ctr2: 2-bit saturating counter next-state logic (inputs cur, taken, force_st; output nxt). Instantiated once on the update path.

Test Plan:
- Reset then lookup pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_npc=0x0000_0044; assert rst=0 mid-run after training -> outputs return to miss immediately, without a clock edge.
- Update upd_pc=0x40, branch, taken, target=0x100 -> next cycle lookup 0x40 gives hit=1, taken=1, npc=0x100. Two not-taken updates -> ctr 10→01→00, taken=0, npc=0x44. Three taken updates -> ctr saturates at 11.
- Not-taken update on a miss at 0x80 -> lookup 0x80 still hit=0.
- Aliasing with ENTRIES=16: train 0x40 taken→0x100, then train 0x440 (same index, different tag) taken→0x200 -> 0x40 misses, 0x440 hits with npc=0x200.
- Same-cycle lookup and update at 0x40 (first taken update) -> that cycle hit=0, following cycle hit=1; flush_all together with upd_valid -> entry stays invalid.
- Jump at 0x60 to 0x300 -> ctr=11, taken=1; one not-taken update leaves taken=1. With BP_STATS_EN defined, 5 updates of which 2 mispredicted -> stat_updates=5, stat_mispred=2.
